// File: rtl/io_input_conditioner.sv
// Board switch/button conditioner: 2-flop synchronizer plus per-bit debounce
// counter, producing stable levels and one-cycle change pulses for the LSU.
module io_input_conditioner #(
   parameter int unsigned SW_DB_CYCLES  = 500000,
   parameter int unsigned BTN_DB_CYCLES = 500000,
   parameter logic [31:0] SW_RST_VAL    = 32'h0000_0000,
   parameter logic [3:0]  BTN_RST_VAL   = 4'hF
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_sw_raw,
   input  logic [3:0]  i_btn_raw,
   output logic [31:0] o_io_sw,
   output logic [3:0]  o_io_btn,
   output logic [3:0]  o_btn_edge,
   output logic        o_sw_chg
);

   localparam int unsigned SW_W   = 32;
   localparam int unsigned BTN_W  = 4;
   localparam int unsigned SW_CW  = $clog2(SW_DB_CYCLES + 1);
   localparam int unsigned BTN_CW = $clog2(BTN_DB_CYCLES + 1);
   localparam logic [SW_CW-1:0]  SW_CNT_MAX  = SW_CW'(SW_DB_CYCLES - 1);
   localparam logic [BTN_CW-1:0] BTN_CNT_MAX = BTN_CW'(BTN_DB_CYCLES - 1);

   logic [SW_W-1:0]   sw_s1_q, sw_s2_q, sw_q, sw_upd_c;
   logic [BTN_W-1:0]  btn_s1_q, btn_s2_q, btn_q, btn_upd_c;
   logic [SW_CW-1:0]  sw_cnt_q  [SW_W];
   logic [SW_CW-1:0]  sw_cnt_d  [SW_W];
   logic [BTN_CW-1:0] btn_cnt_q [BTN_W];
   logic [BTN_CW-1:0] btn_cnt_d [BTN_W];
   logic [BTN_W-1:0]  btn_edge_q;
   logic              sw_chg_q;

   // Debounce next state: count while synchronized level differs, accept at N-1.
   always_comb begin
      sw_upd_c  = '0;
      btn_upd_c = '0;
      for (int i = 0; i < int'(SW_W); i++) begin
         sw_cnt_d[i] = '0;
         if (sw_s2_q[i] != sw_q[i]) begin
            if (sw_cnt_q[i] == SW_CNT_MAX) sw_upd_c[i] = 1'b1;
            else                           sw_cnt_d[i] = sw_cnt_q[i] + SW_CW'(1);
         end
      end
      for (int i = 0; i < int'(BTN_W); i++) begin
         btn_cnt_d[i] = '0;
         if (btn_s2_q[i] != btn_q[i]) begin
            if (btn_cnt_q[i] == BTN_CNT_MAX) btn_upd_c[i] = 1'b1;
            else                             btn_cnt_d[i] = btn_cnt_q[i] + BTN_CW'(1);
         end
      end
   end

   // An accepted update always flips the bit, since s2 differed from stable.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sw_s1_q    <= SW_RST_VAL;
         sw_s2_q    <= SW_RST_VAL;
         sw_q       <= SW_RST_VAL;
         btn_s1_q   <= BTN_RST_VAL;
         btn_s2_q   <= BTN_RST_VAL;
         btn_q      <= BTN_RST_VAL;
         sw_cnt_q   <= '{default: '0};
         btn_cnt_q  <= '{default: '0};
         btn_edge_q <= '0;
         sw_chg_q   <= 1'b0;
      end else begin
         sw_s1_q    <= i_sw_raw;
         sw_s2_q    <= sw_s1_q;
         sw_q       <= sw_q ^ sw_upd_c;
         btn_s1_q   <= i_btn_raw;
         btn_s2_q   <= btn_s1_q;
         btn_q      <= btn_q ^ btn_upd_c;
         sw_cnt_q   <= sw_cnt_d;
         btn_cnt_q  <= btn_cnt_d;
         btn_edge_q <= btn_upd_c;
         sw_chg_q   <= |sw_upd_c;
      end
   end

   assign o_io_sw    = sw_q;
   assign o_io_btn   = btn_q;
   assign o_btn_edge = btn_edge_q;
   assign o_sw_chg   = sw_chg_q;

endmodule

// File: tb/tb_io_input_conditioner.sv
// Bench for io_input_conditioner: directed scenarios plus random pin activity,
// checked every cycle against a sliding-window debounce model.
module tb_io_input_conditioner;

   localparam int unsigned DB   = 4;
   localparam int unsigned HMAX = 8192;
   localparam logic [35:0] RSTV = {4'hF, 32'h0000_0000};

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] sw_raw;
   logic [3:0]  btn_raw;
   logic [31:0] io_sw;
   logic [3:0]  io_btn;
   logic [3:0]  btn_edge;
   logic        sw_chg;

   io_input_conditioner #(
      .SW_DB_CYCLES (DB),
      .BTN_DB_CYCLES(DB),
      .SW_RST_VAL   (32'h0000_0000),
      .BTN_RST_VAL  (4'hF)
   ) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_sw_raw  (sw_raw),
      .i_btn_raw (btn_raw),
      .o_io_sw   (io_sw),
      .o_io_btn  (io_btn),
      .o_btn_edge(btn_edge),
      .o_sw_chg  (sw_chg)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Model: a bit flips once its last DB debounce-input samples, all taken on
   // non-reset edges, disagree with the current stable value. The debounce
   // input at edge t is the pin value sampled at edge t-2 (reset value if
   // either intervening edge was a reset edge).
   logic [35:0] raw_h [HMAX];
   logic [35:0] d_h   [HMAX];
   bit          rst_h [HMAX];
   int          cyc = 0;
   logic [35:0] exp_v = RSTV;
   logic [35:0] exp_flip = '0;
   bit          model_ok = 1'b0;

   always @(posedge clk) begin
      logic [35:0] all_diff;
      raw_h[cyc] = {btn_raw, sw_raw};
      rst_h[cyc] = rst;
      if (cyc >= 2 && !rst_h[cyc-1] && !rst_h[cyc-2]) d_h[cyc] = raw_h[cyc-2];
      else                                           d_h[cyc] = RSTV;
      if (rst) begin
         exp_v    = RSTV;
         exp_flip = '0;
      end else begin
         all_diff = '1;
         for (int j = 0; j < int'(DB); j++) begin
            if (cyc - j < 0 || rst_h[cyc-j]) all_diff = '0;
            else                             all_diff &= d_h[cyc-j] ^ exp_v;
         end
         exp_flip = all_diff;
         exp_v    = exp_v ^ all_diff;
      end
      model_ok = 1'b1;
      if (cyc < int'(HMAX) - 1) cyc++;
   end

   int sw_chg_cnt = 0;
   int btn0_cnt   = 0;

   always @(negedge clk) begin
      if (model_ok) begin
         chk("io_sw",    64'(io_sw),    64'(exp_v[31:0]));
         chk("io_btn",   64'(io_btn),   64'(exp_v[35:32]));
         chk("btn_edge", 64'(btn_edge), 64'(exp_flip[35:32]));
         chk("sw_chg",   64'(sw_chg),   64'(|exp_flip[31:0]));
         sw_chg_cnt += int'(sw_chg);
         btn0_cnt   += int'(btn_edge[0]);
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst     = 1'b1;
      btn_raw = 4'h0;
      sw_raw  = 32'hFFFF_FFFF;

      // 1: reset and acceptance after release
      step(1);
      chk("rst_btn", 64'(io_btn), 64'hF);
      chk("rst_sw",  64'(io_sw),  64'h0);
      step(1);
      chk("rst_edge", 64'({btn_edge, sw_chg}), 64'h0);
      rst = 1'b0;
      step(5);
      chk("rel_btn_early", 64'(io_btn), 64'hF);
      step(1);
      chk("rel_btn", 64'(io_btn), 64'h0);
      chk("rel_sw",  64'(io_sw),  64'hFFFF_FFFF);
      chk("rel_edge", 64'({btn_edge, sw_chg}), 64'h1F);
      step(1);
      chk("rel_edge_clr", 64'({btn_edge, sw_chg}), 64'h0);

      // 2: clean press from idle
      btn_raw = 4'hF;
      sw_raw  = 32'h0;
      step(10);
      btn_raw = 4'hE;
      step(5);
      chk("press_early", 64'(io_btn), 64'hF);
      step(1);
      chk("press_btn",  64'(io_btn),   64'hE);
      chk("press_edge", 64'(btn_edge), 64'h1);
      step(1);
      chk("press_edge_clr", 64'(btn_edge), 64'h0);

      // 3: bounce on bit 0
      btn_raw = 4'hF;
      step(10);
      btn0_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         btn_raw[0] = ~btn_raw[0];
         step(2);
      end
      btn_raw[0] = 1'b0;
      chk("bounce_hold", 64'(io_btn[0]), 64'h1);
      step(12);
      chk("bounce_pulses", 64'(btn0_cnt), 64'd1);
      chk("bounce_final",  64'(io_btn),   64'hE);

      // 4: short switch glitch
      btn_raw = 4'hF;
      step(10);
      sw_chg_cnt = 0;
      sw_raw[5] = 1'b1;
      step(3);
      sw_raw[5] = 1'b0;
      step(10);
      chk("glitch_pulses", 64'(sw_chg_cnt), 64'd0);
      chk("glitch_sw",     64'(io_sw),      64'h0);

      // 5: independent switch bits
      sw_chg_cnt = 0;
      sw_raw[0] = 1'b1;
      step(2);
      sw_raw[31] = 1'b1;
      step(4);
      chk("indep_b0", 64'(io_sw), 64'h0000_0001);
      step(2);
      chk("indep_b31", 64'(io_sw), 64'h8000_0001);
      step(4);
      chk("indep_pulses", 64'(sw_chg_cnt), 64'd2);

      // 6: reset in the middle of a count
      btn_raw = 4'h7;
      step(4);
      rst = 1'b1;
      step(2);
      chk("midrst_btn",  64'(io_btn),   64'hF);
      chk("midrst_edge", 64'(btn_edge), 64'h0);
      rst = 1'b0;
      step(5);
      chk("midrst_early", 64'(io_btn), 64'hF);
      step(1);
      chk("midrst_accept", 64'(io_btn), 64'h7);

      // random pin activity with occasional resets
      for (int i = 0; i < 2500; i++) begin
         rst = 1'b0;
         if ($urandom_range(7, 0) == 0) sw_raw[$urandom_range(31, 0)] ^= 1'b1;
         if ($urandom_range(5, 0) == 0) btn_raw[$urandom_range(3, 0)] ^= 1'b1;
         if ($urandom_range(15, 0) == 0) sw_raw = $urandom();
         if ($urandom_range(299, 0) == 0) rst = 1'b1;
         step(1);
      end
      rst = 1'b0;
      step(10);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/io_input_conditioner.md
Name: io_input_conditioner

Overview:
- Conditions the raw board switch and push-button pins before they reach the load/store unit's input-peripheral port (i_io_sw, i_io_btn).
- Each bit passes through a 2-flop synchronizer and then a per-bit debounce counter.
- Emits clean, stable levels plus one-cycle change pulses.
- Sits between the top-level board pins and the LSU. Software reads at 0x7800-0x781F then see glitch-free values.

Parameters:
- SW_DB_CYCLES, 500000, consecutive cycles a synchronized switch level must hold before it is accepted (10 ms at 50 MHz); legal range >= 1.
- BTN_DB_CYCLES, 500000, same rule for buttons; legal range >= 1.
- SW_RST_VAL, 32'h0000_0000, reset value of the switch synchronizer and output.
- BTN_RST_VAL, 4'hF, reset value of the button synchronizer and output (board buttons are active-low, so released = 1).

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset
- i_sw_raw  in  32  asynchronous switch pins
- i_btn_raw  in  4  asynchronous button pins, raw board polarity
- o_io_sw  out  32  debounced switches, to LSU i_io_sw
- o_io_btn  out  4  debounced buttons, same polarity as raw, to LSU i_io_btn
- o_btn_edge  out  4  per-bit one-cycle pulse on any debounced button change
- o_sw_chg  out  1  one-cycle pulse when any debounced switch bit changes

Behaviour:
- Clock and reset: one clock, i_clk (rising edge). i_rst is synchronous and active-high.
- Reset values:
  - sync stages s1/s2 = SW_RST_VAL / BTN_RST_VAL
  - o_io_sw = SW_RST_VAL, o_io_btn = BTN_RST_VAL
  - all counters = 0, o_btn_edge = 0, o_sw_chg = 0
- Reset priority: reset overrides every other update, including mid-count.
- Synchronizer: s1 <= raw; s2 <= s1, every edge. No logic between s1 and s2.
- Per-bit debounce, with stable = output register and N = the parameter for that bit:
  - If s2 == stable: cnt <= 0.
  - Else if cnt == N-1: stable <= s2, cnt <= 0.
  - Else: cnt <= cnt + 1.
  - Counter width is $clog2(N+1). There is no wrap: cnt never exceeds N-1.
- Latency:
  - A raw change set up before edge k appears on the output after edge k+N+1, i.e. N+2 edges total.
  - N=1 gives 3 edges.
- Glitch rejection: any single s2 sample equal to stable clears cnt. A pulse shorter than N cycles (post-synchronizer) never reaches the output.
- Bits are fully independent: separate counters, no shared timer.
- Simultaneous changes on several bits each update on their own schedule.
- o_btn_edge[i] is registered and is 1 in exactly the cycle where o_io_btn[i] first shows the new value; otherwise 0.
- o_sw_chg is 1 in exactly the cycle where at least one o_io_sw bit first shows a new value.
  - Several bits updating in the same cycle give one pulse.
  - Updates in consecutive cycles give consecutive pulses.
- Reset release: the first edge with i_rst low samples raw into s1. A raw level differing from the reset value is accepted N+2 edges after the first non-reset edge. No edge pulse is generated by reset itself.
- Purely sequential datapath: no combinational path from any input to any output.

Test Plan (SW_DB_CYCLES = BTN_DB_CYCLES = 4):
1. Reset: i_rst=1 for 2 edges with i_btn_raw=4'h0, i_sw_raw=32'hFFFF_FFFF -> o_io_btn=4'hF, o_io_sw=0, o_btn_edge=0, o_sw_chg=0 throughout reset. After release, with raw held: o_io_btn=4'h0 and o_io_sw=32'hFFFF_FFFF exactly 6 edges after the first non-reset edge, with o_btn_edge=4'hF and o_sw_chg=1 for one cycle.
2. Clean press: from idle 4'hF, drive i_btn_raw=4'hE and hold -> o_io_btn=4'hE exactly 6 edges later, o_btn_edge=4'h1 for that single cycle, then 0.
3. Bounce: toggle i_btn_raw[0] every 2 cycles for 20 cycles, then settle at 0 -> o_io_btn[0] stays 1 during bounce, changes 6 edges after the last transition, exactly one o_btn_edge[0] pulse.
4. Glitch reject: i_sw_raw[5] high for 3 cycles then low -> o_io_sw never changes, o_sw_chg never asserts.
5. Independent bits: i_sw_raw[0] rises at cycle t, i_sw_raw[31] rises at t+2 -> o_io_sw[0] updates at t+6 and o_io_sw[31] at t+8, two separate o_sw_chg pulses.
6. Reset mid-count: change i_btn_raw to 4'h7, assert i_rst once cnt[3]=2 -> o_io_btn=4'hF, no edge pulse. After release with raw still 4'h7, o_io_btn=4'h7 exactly 6 edges after the first non-reset edge.
